gslcd_timing_gen: RTL and testbench

//  Parametrised LCD raster engine for the gslcd display path: generates HSYNC/VSYNC/DEN.

---
 rtl/gslcd_pkg.sv | 40 ++++
 rtl/gslcd_pattern_gen.sv | 81 ++++++++
 rtl/gslcd_timing_gen.sv | 187 ++++++++++++++++++
 tb/tb_gslcd_timing_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gslcd_pkg.sv
// gslcd_pkg
//  Shared definitions for the gslcd raster engine: pixel source mode
//  encodings and the 8:8:8 RGB colours used by the colour-bar pattern.
//  No ports; imported by gslcd_timing_gen and gslcd_pattern_gen.
package gslcd_pkg;

    typedef enum logic [1:0] {
        MODE_STREAM = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_SOLID  = 2'd2,
        MODE_RAMP   = 2'd3
    } gslcd_mode_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Bar index 0..7 maps to the bar colours; index 8 marks the remainder
    // pixels past the last full bar, which stay black.
    function automatic logic [23:0] bar_color(input logic [3:0] idx);
        logic [23:0] col;
        case (idx)
            4'd0:    col = BAR_WHITE;
            4'd1:    col = BAR_YELLOW;
            4'd2:    col = BAR_CYAN;
            4'd3:    col = BAR_GREEN;
            4'd4:    col = BAR_MAGENTA;
            4'd5:    col = BAR_RED;
            4'd6:    col = BAR_BLUE;
            default: col = BAR_BLACK;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/gslcd_pattern_gen.sv
// gslcd_pattern_gen
//  Built-in test pattern source. Produces the pattern pixel for the raster
//  position currently held in the top-level counters.
//  Ports:
//   clk_i, rst_ni      pixel clock, async active-low reset
//   adv_i              raster counters advance this cycle (engine running)
//   h_i                current horizontal position
//   v_lo_i             low byte of the current line number
//   mode_i             latched pixel source mode
//   solid_color_i      colour for the solid pattern
//   pixel_o            pattern pixel (zero in stream mode)
module gslcd_pattern_gen
    import gslcd_pkg::*;
#(
    parameter int H_ACTIVE   = 800,
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  adv_i,
    input  logic [CNT_WIDTH-1:0]  h_i,
    input  logic [7:0]            v_lo_i,
    input  gslcd_mode_e           mode_i,
    input  logic [DATA_WIDTH-1:0] solid_color_i,
    output logic [DATA_WIDTH-1:0] pixel_o
);

    localparam int                   BAR_W      = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [CNT_WIDTH-1:0] BAR_LAST   = CNT_WIDTH'(BAR_W - 1);
    localparam logic [CNT_WIDTH-1:0] H_LAST_ACT = CNT_WIDTH'(H_ACTIVE - 1);

    // bar_px_q/bar_idx_q always describe the pixel at h_i; they restart at
    // every line so no divider is needed to find the bar.
    logic [CNT_WIDTH-1:0] bar_px_q, bar_px_d;
    logic [3:0]           bar_idx_q, bar_idx_d;
    logic [7:0]           h_lo_s;

    assign h_lo_s = 8'(h_i);

    // Next bar position: step within the active part of the line, else restart.
    always_comb begin
        bar_px_d  = '0;
        bar_idx_d = 4'd0;
        if (adv_i && (h_i < H_LAST_ACT)) begin
            if (bar_px_q == BAR_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = (bar_idx_q == 4'd8) ? 4'd8 : bar_idx_q + 4'd1;
            end else begin
                bar_px_d  = bar_px_q + CNT_WIDTH'(1);
                bar_idx_d = bar_idx_q;
            end
        end else begin
            bar_px_d  = '0;
            bar_idx_d = 4'd0;
        end
    end

    // Bar position registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bar_px_q  <= '0;
            bar_idx_q <= 4'd0;
        end else begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // Pattern pixel select.
    always_comb begin
        pixel_o = '0;
        case (mode_i)
            MODE_BARS:  pixel_o = DATA_WIDTH'(bar_color(bar_idx_q));
            MODE_SOLID: pixel_o = solid_color_i;
            MODE_RAMP:  pixel_o = DATA_WIDTH'({h_lo_s, v_lo_i, h_lo_s ^ v_lo_i});
            default:    pixel_o = '0;
        endcase
    end

endmodule

// File: rtl/gslcd_timing_gen.sv
// gslcd_timing_gen
//  LCD raster engine: h/v counters, sync/data-enable generation, stream
//  pixel handshake or built-in test patterns, underflow and frame-start flags.
//  Everything runs on the rising edge of LCD_PCLK.
//  Ports:
//   LCD_PCLK, LCD_ARESETN      pixel clock, async active-low reset
//   enable, mode               run request and pixel source, taken at frame boundary
//   solid_color                colour for the solid pattern
//   s_tdata/s_tvalid/s_tready  upstream pixel stream (s_tready combinational)
//   underflow_clr, underflow   sticky underflow flag and its clear
//   frame_start                pulse one cycle before the first DEN of a frame
//   LCD_DEN/HSYNC/VSYNC/DATA   registered LCD pin outputs
module gslcd_timing_gen
    import gslcd_pkg::*;
#(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 48,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 13,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 32,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  LCD_PCLK,
    input  logic                  LCD_ARESETN,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] solid_color,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  underflow_clr,
    output logic                  underflow,
    output logic                  frame_start,
    output logic                  LCD_DEN,
    output logic                  LCD_HSYNC,
    output logic                  LCD_VSYNC,
    output logic [DATA_WIDTH-1:0] LCD_DATA
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_WIDTH-1:0] H_ACT_C   = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] H_SYNC0_C = CNT_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [CNT_WIDTH-1:0] H_SYNC1_C = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] H_LAST_C  = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_ACT_C   = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] V_SYNC0_C = CNT_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [CNT_WIDTH-1:0] V_SYNC1_C = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_WIDTH-1:0] V_LAST_C  = CNT_WIDTH'(V_TOTAL - 1);

    logic [CNT_WIDTH-1:0]  h_q, h_d, v_q, v_d;
    logic                  running_q, running_d;
    gslcd_mode_e           mode_q, mode_d;
    logic                  den_q, den_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  underflow_q, underflow_d;
    logic                  frame_start_q, frame_start_d;

    logic                  frame_end_s;
    logic                  active_s;
    logic                  hsync_act_s;
    logic                  vsync_act_s;
    logic                  s_tready_s;
    logic [DATA_WIDTH-1:0] pattern_s;

    // While idle every cycle counts as a frame boundary so a new enable is
    // picked up immediately.
    assign frame_end_s = !running_q || ((h_q == H_LAST_C) && (v_q == V_LAST_C));
    assign active_s    = running_q && (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hsync_act_s = running_q && (h_q >= H_SYNC0_C) && (h_q < H_SYNC1_C);
    assign vsync_act_s = running_q && (v_q >= V_SYNC0_C) && (v_q < V_SYNC1_C);
    assign s_tready_s  = active_s && (mode_q == MODE_STREAM);

    gslcd_pattern_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pattern (
        .clk_i         (LCD_PCLK),
        .rst_ni        (LCD_ARESETN),
        .adv_i         (running_q),
        .h_i           (h_q),
        .v_lo_i        (8'(v_q)),
        .mode_i        (mode_q),
        .solid_color_i (solid_color),
        .pixel_o       (pattern_s)
    );

    // Next-state for counters, frame latch, flags and the registered pins.
    always_comb begin
        h_d           = '0;
        v_d           = '0;
        running_d     = running_q;
        mode_d        = mode_q;
        data_d        = '0;
        underflow_d   = underflow_q;

        if (frame_end_s) begin
            running_d = enable;
            mode_d    = gslcd_mode_e'(mode);
        end else begin
            running_d = running_q;
            mode_d    = mode_q;
        end

        // Counters hold at 0 while idle; the frame-end wrap also lands on 0.
        if (!running_q) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST_C) begin
            h_d = '0;
            v_d = (v_q == V_LAST_C) ? '0 : v_q + CNT_WIDTH'(1);
        end else begin
            h_d = h_q + CNT_WIDTH'(1);
            v_d = v_q;
        end

        frame_start_d = running_d && (h_d == '0) && (v_d == '0);

        // A missing stream beat blanks its pixel; timing never stalls.
        if (!active_s) begin
            data_d = '0;
        end else if (mode_q == MODE_STREAM) begin
            data_d = s_tvalid ? s_tdata : '0;
        end else begin
            data_d = pattern_s;
        end

        // Set has priority over clear.
        if (s_tready_s && !s_tvalid) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end

        den_d   = active_s;
        hsync_d = hsync_act_s ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = vsync_act_s ? VSYNC_POL : ~VSYNC_POL;
    end

    // State and output registers.
    always_ff @(posedge LCD_PCLK or negedge LCD_ARESETN) begin
        if (!LCD_ARESETN) begin
            h_q           <= '0;
            v_q           <= '0;
            running_q     <= 1'b0;
            mode_q        <= MODE_STREAM;
            den_q         <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            data_q        <= '0;
            underflow_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            running_q     <= running_d;
            mode_q        <= mode_d;
            den_q         <= den_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            data_q        <= data_d;
            underflow_q   <= underflow_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign s_tready    = s_tready_s;
    assign underflow   = underflow_q;
    assign frame_start = frame_start_q;
    assign LCD_DEN     = den_q;
    assign LCD_HSYNC   = hsync_q;
    assign LCD_VSYNC   = vsync_q;
    assign LCD_DATA    = data_q;

endmodule

// File: tb/tb_gslcd_timing_gen.sv
// Testbench for gslcd_timing_gen: a small-raster instance (H 8/2/2/2,
// V 4/1/1/1) for timing/stream/underflow/mode checks and an 800-pixel-wide
// instance for colour-bar widths.
module tb_gslcd_timing_gen;

    localparam logic [23:0] SOLID = 24'h123456;
    localparam logic [23:0] BARS_EXP [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        underflow_clr;
    logic        underflow;
    logic        frame_start;
    logic        den, hsync, vsync;
    logic [23:0] data;

    logic        en_w;
    logic        w_tready, w_uf, w_fs, w_den, w_hs, w_vs;
    logic [23:0] w_data;

    int checks = 0;
    int errors = 0;
    logic uf_m = 1'b0;

    gslcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .LCD_PCLK(clk), .LCD_ARESETN(rst_n), .enable(enable), .mode(mode),
        .solid_color(SOLID), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .underflow_clr(underflow_clr), .underflow(underflow), .frame_start(frame_start),
        .LCD_DEN(den), .LCD_HSYNC(hsync), .LCD_VSYNC(vsync), .LCD_DATA(data)
    );

    gslcd_timing_gen #(
        .H_ACTIVE(800), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_w (
        .LCD_PCLK(clk), .LCD_ARESETN(rst_n), .enable(en_w), .mode(2'd1),
        .solid_color(24'h000000), .s_tdata(24'h000000), .s_tvalid(1'b0), .s_tready(w_tready),
        .underflow_clr(1'b0), .underflow(w_uf), .frame_start(w_fs),
        .LCD_DEN(w_den), .LCD_HSYNC(w_hs), .LCD_VSYNC(w_vs), .LCD_DATA(w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full 98-cycle frame of the small instance. Entered at the negedge
    // where the counters sit at (0,0); outputs seen at cycle c belong to c-1.
    task automatic run_frame(input logic [1:0] fmode, input int drop_a, input int drop_b,
                             input int clr_a, input int clr_b, input int chg_c,
                             input logic chg_en, input logic [1:0] chg_mode);
        int h, v;
        logic act, prev_act, prev_hs, prev_vs;
        logic [23:0] pix, prev_pix;
        prev_act = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0; prev_pix = 24'h0;
        for (int c = 0; c < 98; c++) begin
            h   = c % 14;
            v   = c / 14;
            act = (h < 8) && (v < 4);
            s_tvalid      = !((c == drop_a) || (c == drop_b));
            s_tdata       = act ? 24'(v * 8 + h) : 24'hABCDEF;
            underflow_clr = (c == clr_a) || (c == clr_b);
            if (c == chg_c) begin
                enable = chg_en;
                mode   = chg_mode;
            end
            check("frame_start", frame_start, (c == 0));
            check("s_tready", s_tready, (fmode == 2'd0) && act);
            check("den", den, prev_act);
            check("hsync", hsync, !prev_hs);
            check("vsync", vsync, !prev_vs);
            check("data", data, prev_pix);
            check("underflow", underflow, uf_m);
            case (fmode)
                2'd0:    pix = s_tvalid ? 24'(v * 8 + h) : 24'h0;
                2'd1:    pix = BARS_EXP[h % 8];
                2'd2:    pix = SOLID;
                default: pix = {8'(h), 8'(v), 8'(h ^ v)};
            endcase
            prev_pix = act ? pix : 24'h0;
            prev_act = act;
            prev_hs  = (h >= 10) && (h < 12);
            prev_vs  = (v == 5);
            if ((fmode == 2'd0) && act && !s_tvalid) uf_m = 1'b1;
            else if (underflow_clr) uf_m = 1'b0;
            @(negedge clk);
        end
        underflow_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; mode = 2'd0; s_tdata = 24'h0; s_tvalid = 1'b1;
        underflow_clr = 1'b0; en_w = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_den", den, 1'b0);
        check("rst_data", data, 24'h0);
        check("rst_hsync", hsync, 1'b1);
        check("rst_vsync", vsync, 1'b1);
        check("rst_tready", s_tready, 1'b0);
        check("rst_underflow", underflow, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_w_den", w_den, 1'b0);

        // Wide instance: 8 bars of 100 px on the first line.
        rst_n = 1'b1; en_w = 1'b1;
        @(negedge clk);
        check("w_frame_start", w_fs, 1'b1);
        for (int c = 1; c <= 801; c++) begin
            @(negedge clk);
            if (c == 1) check("w_frame_start_end", w_fs, 1'b0);
            check("w_den", w_den, (c - 1) < 800);
            check("w_data", w_data, ((c - 1) < 800) ? BARS_EXP[(c - 1) / 100] : 24'h0);
        end
        en_w = 1'b0;

        // Small instance: clean stream frame, then underflow frame.
        enable = 1'b1; mode = 2'd0;
        @(negedge clk);
        run_frame(2'd0, -1, -1, -1, -1, -1, 1'b1, 2'd0);
        run_frame(2'd0, 17, 33, 33, 40, -1, 1'b1, 2'd0);

        // Mid-frame switch to bars and disable: frame completes as stream.
        run_frame(2'd0, -1, -1, -1, -1, 50, 1'b0, 2'd1);
        for (int i = 0; i < 4; i++) begin
            check("idle_den", den, 1'b0);
            check("idle_frame_start", frame_start, 1'b0);
            check("idle_tready", s_tready, 1'b0);
            check("idle_hsync", hsync, 1'b1);
            @(negedge clk);
        end

        // Re-enable: bars frame, switching to ramp for the next frame.
        enable = 1'b1;
        @(negedge clk);
        run_frame(2'd1, -1, -1, -1, -1, 60, 1'b1, 2'd3);
        run_frame(2'd3, -1, -1, -1, -1, -1, 1'b1, 2'd3);

        // Asynchronous reset mid-line (pixel (5,1) on the pins).
        repeat (20) @(negedge clk);
        check("pre_rst_den", den, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_den", den, 1'b0);
        check("arst_data", data, 24'h0);
        check("arst_hsync", hsync, 1'b1);
        check("arst_vsync", vsync, 1'b1);
        check("arst_tready", s_tready, 1'b0);
        check("arst_frame_start", frame_start, 1'b0);
        mode = 2'd0; enable = 1'b1; s_tvalid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; uf_m = 1'b0;
        @(negedge clk);
        run_frame(2'd0, -1, -1, -1, -1, -1, 1'b1, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
